// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line idle level and FSM state encodings.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t StIdle  = 2'd0;
    localparam uart_state_t StStart = 2'd1;
    localparam uart_state_t StData  = 2'd2;
    localparam uart_state_t StStop  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the serial line with falling-edge detect on the settled copy.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic serial_i,
    output logic line_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Reset to idle level so a reset never fakes a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= IDLE_LEVEL;
            s2_q <= IDLE_LEVEL;
            s3_q <= IDLE_LEVEL;
        end else begin
            s1_q <= serial_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign line_o = s2_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/uart_rxd_ctrl.sv
// 8N1 UART receiver: start validation, mid-bit sampling and a host data register with
// ready, framing-error and overrun-error flags.
module uart_rxd_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 read_rcv_datareg,
    output logic [DATA_BITS-1:0] data_bus,
    output logic                 rcv_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] CntHalfLast = CntW'(HALF - 1);
    localparam logic [CntW-1:0] CntBitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    logic line;
    logic fall;

    uart_rx_sync u_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .serial_i (serial_in),
        .line_o   (line),
        .fall_o   (fall)
    );

    uart_state_t          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 stop_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        stop_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalfLast) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_d = line ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == CntBitLast) begin
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                if (cnt_q == CntBitLast) begin
                    stop_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Frame completion is applied after the host clear so that a same-cycle set wins.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (read_rcv_datareg && ready_q) begin
            ready_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
        if (stop_done) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            ferr_d  = ~line;
            if (ready_q && !read_rcv_datareg) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_bus      = data_q;
    assign rcv_ready     = ready_q;
    assign framing_error = ferr_q;
    assign overrun_error = ovr_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rxd_ctrl.sv
// Directed bench for uart_rxd_ctrl; edge numbers are counted from the first low-registering edge.
module tb_uart_rxd_ctrl;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       read_rcv_datareg;
    logic [7:0] data_bus;
    logic       rcv_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int unsigned cyc = 0;
    int unsigned base = 0;
    int          total = 0;
    int          bad = 0;

    uart_rxd_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk              (clk),
        .rst              (rst),
        .serial_in        (serial_in),
        .read_rcv_datareg (read_rcv_datareg),
        .data_bus         (data_bus),
        .rcv_ready        (rcv_ready),
        .framing_error    (framing_error),
        .overrun_error    (overrun_error),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return at the negedge following frame edge e.
    task automatic wait_edge(input int unsigned e);
        while (cyc < base + e + 1) @(negedge clk);
    endtask

    // Start bit and eight data bits; the caller then drives the stop level.
    task automatic send_body(input logic [7:0] d);
        base      = cyc;
        serial_in = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            hold(CPB);
        end
    endtask

    task automatic host_read();
        read_rcv_datareg = 1'b1;
        hold(1);
        read_rcv_datareg = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        serial_in        = 1'b1;
        read_rcv_datareg = 1'b0;
        @(negedge clk);
        hold(3);
        chk("rst_data", data_bus, 8'h00);
        chk("rst_ready", {7'd0, rcv_ready}, 8'd0);
        chk("rst_ferr", {7'd0, framing_error}, 8'd0);
        chk("rst_ovr", {7'd0, overrun_error}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b0;
        hold(5);

        // Clean frame 0xA5.
        send_body(8'hA5);
        serial_in = 1'b1;
        wait_edge(153);
        chk("a5_ready_153", {7'd0, rcv_ready}, 8'd0);
        chk("a5_busy_153", {7'd0, busy}, 8'd1);
        wait_edge(154);
        chk("a5_data", data_bus, 8'hA5);
        chk("a5_ready", {7'd0, rcv_ready}, 8'd1);
        chk("a5_ferr", {7'd0, framing_error}, 8'd0);
        chk("a5_busy_154", {7'd0, busy}, 8'd0);
        wait_edge(159);
        host_read();
        chk("a5_read_clr", {7'd0, rcv_ready}, 8'd0);
        hold(10);

        // Four-cycle low glitch.
        base      = cyc;
        serial_in = 1'b0;
        wait_edge(1);
        chk("gl_busy_1", {7'd0, busy}, 8'd0);
        wait_edge(2);
        chk("gl_busy_2", {7'd0, busy}, 8'd1);
        wait_edge(3);
        serial_in = 1'b1;
        wait_edge(9);
        chk("gl_busy_9", {7'd0, busy}, 8'd1);
        wait_edge(10);
        chk("gl_busy_10", {7'd0, busy}, 8'd0);
        chk("gl_ready", {7'd0, rcv_ready}, 8'd0);
        chk("gl_data", data_bus, 8'hA5);
        chk("gl_errs", {6'd0, framing_error, overrun_error}, 8'd0);
        hold(20);

        // 0x3C with a low stop bit, line held low, then a good 0x11.
        send_body(8'h3C);
        serial_in = 1'b0;
        wait_edge(154);
        chk("fe_data", data_bus, 8'h3C);
        chk("fe_ready", {7'd0, rcv_ready}, 8'd1);
        chk("fe_ferr", {7'd0, framing_error}, 8'd1);
        wait_edge(180);
        chk("fe_low_busy", {7'd0, busy}, 8'd0);
        wait_edge(199);
        serial_in = 1'b1;
        chk("fe_low_busy_end", {7'd0, busy}, 8'd0);
        host_read();
        chk("fe_read_ready", {7'd0, rcv_ready}, 8'd0);
        chk("fe_read_ferr", {7'd0, framing_error}, 8'd0);
        hold(20);
        send_body(8'h11);
        serial_in = 1'b1;
        wait_edge(154);
        chk("x11_data", data_bus, 8'h11);
        chk("x11_ready", {7'd0, rcv_ready}, 8'd1);
        chk("x11_ferr", {7'd0, framing_error}, 8'd0);
        wait_edge(159);
        host_read();
        hold(5);

        // Back-to-back 0x55 then 0xAA with no read.
        send_body(8'h55);
        serial_in = 1'b1;
        wait_edge(154);
        chk("b2b_data0", data_bus, 8'h55);
        wait_edge(159);
        send_body(8'hAA);
        serial_in = 1'b1;
        wait_edge(154);
        chk("b2b_data1", data_bus, 8'hAA);
        chk("b2b_ready", {7'd0, rcv_ready}, 8'd1);
        chk("b2b_ovr", {7'd0, overrun_error}, 8'd1);
        chk("b2b_ferr", {7'd0, framing_error}, 8'd0);
        wait_edge(159);
        host_read();
        chk("b2b_clr", {5'd0, rcv_ready, framing_error, overrun_error}, 8'd0);
        hold(5);

        // Read on the same edge 0x7E completes while a byte is pending.
        send_body(8'h81);
        serial_in = 1'b1;
        wait_edge(159);
        chk("rw_pending", {7'd0, rcv_ready}, 8'd1);
        send_body(8'h7E);
        serial_in = 1'b1;
        wait_edge(153);
        read_rcv_datareg = 1'b1;
        wait_edge(154);
        read_rcv_datareg = 1'b0;
        chk("rw_ready", {7'd0, rcv_ready}, 8'd1);
        chk("rw_data", data_bus, 8'h7E);
        chk("rw_ovr", {7'd0, overrun_error}, 8'd0);
        wait_edge(159);

        // Reset during data bit 3, then 0xC3.
        base      = cyc;
        serial_in = 1'b0;
        hold(CPB);
        serial_in = 1'b1;
        hold(3 * CPB);
        serial_in = 1'b0;
        hold(CPB / 2);
        chk("mr_busy", {7'd0, busy}, 8'd1);
        rst       = 1'b1;
        serial_in = 1'b1;
        hold(1);
        chk("mr_data", data_bus, 8'h00);
        chk("mr_flags", {4'd0, rcv_ready, framing_error, overrun_error, busy}, 8'd0);
        rst = 1'b0;
        hold(20);
        send_body(8'hC3);
        serial_in = 1'b1;
        wait_edge(153);
        chk("c3_ready_153", {7'd0, rcv_ready}, 8'd0);
        wait_edge(154);
        chk("c3_data", data_bus, 8'hC3);
        chk("c3_ready", {7'd0, rcv_ready}, 8'd1);
        chk("c3_errs", {6'd0, framing_error, overrun_error}, 8'd0);
        wait_edge(159);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rxd_ctrl.md
# uart_rxd_ctrl

UART receiver that pairs with the board's existing serial transmitter. It deserialises 8N1 frames (start 0, eight data bits LSB first, stop 1) from an oversampled serial line and holds each received byte in a data register for the host. The register handshake mirrors the transmit side: a ready flag, a host read strobe, and error flags. The block sits between the board's serial pin and the IIC/peripheral control host logic.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, ≥4
- HALF (derived, not overridable), CLKS_PER_BIT/2, start-bit mid-sample offset
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  asynchronous UART line, idle high
- read_rcv_datareg  in  1  host strobe, 1 cycle: host has taken data_bus
- data_bus  out  8  last received byte
- rcv_ready  out  1  data_bus holds an unread byte
- framing_error  out  1  sticky: the last completed frame had a stop bit of 0
- overrun_error  out  1  sticky: a byte was written while rcv_ready=1
- busy  out  1  a frame is being received (state ≠ IDLE)

## Operation
- Input path: s1 ← serial_in, s2 ← s1, s3 ← s2. Reset value of each is 1.
- Start detect: falling edge, s2==0 && s3==1. A line held low never starts a second frame.
- State machine: IDLE, START, DATA, STOP, plus a bit counter cnt and a bit index idx (0..7).
  - IDLE: on start detect, go to START with cnt=0.
  - START: cnt increments. When cnt==HALF-1 and s2==1 (glitch), return to IDLE. When cnt==HALF-1 and s2==0, go to DATA with cnt=0, idx=0.
  - DATA: cnt increments. When cnt==CLKS_PER_BIT-1, shift s2 in at bit 7 of the shift register (shift right), set cnt=0, increment idx. After idx==7 is sampled, go to STOP.
  - STOP: when cnt==CLKS_PER_BIT-1:
    - data_bus ← shift register; rcv_ready ← 1.
    - framing_error ← ~s2.
    - If rcv_ready was already 1 and read_rcv_datareg is not asserted in the same cycle, overrun_error ← 1. The old byte is overwritten.
    - Go to IDLE.
- read_rcv_datareg clears rcv_ready, framing_error and overrun_error on the next edge. A set from frame completion in the same cycle wins over the clear.
- read_rcv_datareg while rcv_ready=0 has no effect.
- Reset, including mid-frame: state IDLE, cnt/idx/shift register 0, data_bus 0x00, rcv_ready 0, framing_error 0, overrun_error 0, busy 0.

## Timing
- Edge 0 is the first clk edge that registers serial_in low into s1.
  - Start detect takes effect at edge 2.
  - The start bit is validated at edge 2+HALF.
  - Data bit n (n=0..7) is sampled at edge 2+HALF+(n+1)·CLKS_PER_BIT.
  - The stop bit is sampled, and rcv_ready rises, at edge 2+HALF+9·CLKS_PER_BIT; this is 154 for the default.
- The line value used at each sample was present on serial_in at the bit centre (HALF cycles into the bit).
- busy rises at edge 2 and falls at the stop-sample edge or at the glitch reject edge (2+HALF).
- The receiver accepts the next start edge from the cycle after it returns to IDLE. Back-to-back frames with a full stop bit are received without loss.
- cnt is $clog2(CLKS_PER_BIT) bits wide and is compared, never wrapped. idx is 3 bits.

## Structure
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - DATA_BITS=8
  - IDLE_LEVEL=1'b1
  - shared with the transmitter
- Sub-module uart_rx_sync: the 3-flop chain with reset-to-1 and the falling-edge detect output. The FSM, counters, shift register and host register stay in uart_rxd_ctrl.

## Test plan
- Frame 0xA5, CLKS_PER_BIT=16, no read → data_bus=0xA5 and rcv_ready=1 at edge 154; framing_error=0; busy low from edge 154.
- Low pulse of 4 cycles on an idle line → busy high from edge 2 to edge 10; rcv_ready, data_bus and both error flags unchanged.
- Frame 0x3C with stop bit 0, line kept low for 40 cycles, then a valid frame 0x11 → data_bus=0x3C and framing_error=1 first; no frame starts while the line stays low; after a read, 0x11 is received with framing_error=0.
- Frames 0x55 then 0xAA back-to-back with no read → data_bus=0xAA, rcv_ready=1, overrun_error=1; a read strobe clears all three flags on the next edge.
- read_rcv_datareg asserted on the same edge that 0x7E completes while rcv_ready=1 → rcv_ready stays 1, data_bus=0x7E, overrun_error stays 0.
- rst pulsed during data bit 3 of a frame → all outputs at reset values on the next edge; a following 0xC3 frame is received correctly at edge 154.
